sft_arb: RTL and testbench
==========================

Name: sft_arb

Overview:
- Round-robin arbiter and sequencer that shares one `shift` serial-register engine among NREQ requesters (CPU register path, LED/voltage sequencers).
- Issues one command at a time on the engine's vld/cmd/cmd_oen/din interface and waits for the engine's done.
- Acks the owning requester on completion.
- Supports locked multi-command sequences (e.g. 8 shifts + store) that must not interleave with other requesters.

Parameters:
- NREQ, 3, number of requesters (2..8).
- TMO_W, 16, width of the done-timeout counter.
- TMO_CYC, 16'hFFFF, WAIT cycles before timeout abort (used only with SFT_ARB_TMO_EN).

Ports:
- CLK_I  in  1  system clock.
- RST_I  in  1  synchronous active-high reset.
- REQ_VLD  in  NREQ  per-requester command valid; level, held until REQ_TAKE.
- REQ_LOCK  in  NREQ  keep grant after this command completes.
- REQ_CMD  in  2*NREQ  per-requester cmd: 00 master reset, 01 shift, 10 store, 11 output enable.
- REQ_OEN  in  NREQ  per-requester cmd_oen value.
- REQ_DIN  in  8*NREQ  per-requester shift byte.
- REQ_TAKE  out  NREQ  1-cycle pulse: command latched.
- REQ_ACK  out  NREQ  1-cycle pulse: command complete.
- REQ_GNT  out  NREQ  one-hot current owner; all-zero when idle.
- SFT_VLD  out  1  1-cycle command strobe to the engine.
- SFT_CMD  out  2  latched cmd.
- SFT_OEN  out  1  latched cmd_oen.
- SFT_DIN  out  8  latched byte.
- SFT_DONE  in  1  engine completion pulse.
- BUSY  out  1  state != IDLE.
- ERR  out  1  1-cycle timeout pulse; constant 0 without SFT_ARB_TMO_EN.

Behaviour:
- Reset:
  - State IDLE.
  - REQ_TAKE, REQ_ACK, REQ_GNT, SFT_VLD, SFT_CMD, SFT_OEN, SFT_DIN, BUSY, ERR all 0.
  - Round-robin pointer last = NREQ-1, so requester 0 has highest priority first.
  - A reset mid-command abandons the command without an ack. The engine shares RST_I.
- State IDLE:
  - If any REQ_VLD at edge t: winner g is the first set bit searching last+1, last+2, ... modulo NREQ.
  - At edge t: latch g's cmd/oen/din into SFT_*, set REQ_GNT[g] and last=g, go WAIT.
  - Cycle t+1: SFT_VLD=1 and REQ_TAKE[g]=1, both for exactly one cycle.
- State WAIT:
  - REQ_VLD is ignored.
  - SFT_DONE is honoured only from the cycle after SFT_VLD; a done in the SFT_VLD cycle is ignored.
  - On SFT_DONE: REQ_ACK[g]=1 in the next cycle.
  - Next state is HOLD if REQ_LOCK[g] is sampled 1 in the done cycle, else IDLE with REQ_GNT cleared.
- State HOLD:
  - REQ_GNT[g] stays set. Other requesters are blocked.
  - If REQ_VLD[g]: latch and go WAIT with the same timing as IDLE (TAKE/SFT_VLD next cycle).
  - Else if !REQ_LOCK[g]: go IDLE, clear GNT.
  - Otherwise wait. HOLD is unbounded by design.
- Ordering: REQ_ACK and REQ_TAKE never both set for the same requester in the same cycle. Min back-to-back command spacing in HOLD: done → ack → take = 2 cycles.
- Simultaneous requests: exactly one grant per arbitration. A requester whose VLD drops before grant simply loses its slot; there is no error.
- Fairness: with all NREQ requesting continuously and unlocked, grants rotate 0,1,2,0,...
- Output registers: all outputs registered except BUSY, which is a decode of the state register.

Optional Feature:
- Macro: SFT_ARB_TMO_EN.
- With the macro defined:
  - TMO_W-bit counter cleared on entering WAIT, incremented each WAIT cycle.
  - When it reaches TMO_CYC without SFT_DONE: ERR=1 and REQ_ACK[g]=1 in the next cycle, then go IDLE with GNT cleared, ignoring REQ_LOCK.
  - A done arriving in the same cycle as expiry wins: normal ack, no ERR.
- Without the macro: no counter, ERR tied 0, WAIT waits indefinitely.

Decomposition:
- Shared package/define file (alongside the existing shift/twi defines):
  - state encodings SA_IDLE=2'd0, SA_WAIT=2'd1, SA_HOLD=2'd2.
  - command codes SFT_CMD_MR=2'b00, SFT_CMD_SHIFT=2'b01, SFT_CMD_STORE=2'b10, SFT_CMD_OE=2'b11.
- One sub-module, rr_pick: combinational NREQ-wide round-robin one-hot picker taking vld and last, returning gnt_oh and gnt_idx.

Test Plan:
- Single request: REQ_VLD=001, cmd 01, din 8'hA5, done returned 5 cycles after SFT_VLD → TAKE[0] and SFT_VLD in cycle 1 with SFT_DIN=A5, ACK[0] 1 cycle after done, GNT back to 000, BUSY low.
- Contention: REQ_VLD=111 held, unlocked, auto-done after 3 cycles → grant order 0,1,2,0,1,2; each ACK 1-cycle.
- Lock: req1 locked issues 8 shifts (din 01..80) then store with lock dropped, while req0/req2 request continuously → no GNT change until after the store ack; next grant goes to 2.
- Spurious done: SFT_DONE asserted in IDLE and in the SFT_VLD cycle → no ACK. The real done later gives exactly one ACK.
- Reset mid-WAIT: RST_I for 1 cycle during WAIT → next cycle all outputs 0, no ACK. A subsequent VLD=110 grants requester 1.
- With SFT_ARB_TMO_EN, TMO_CYC=16, no done → ERR and ACK[g] 17 cycles after SFT_VLD, then IDLE even with REQ_LOCK=1. Same run with done at the expiry cycle → no ERR.

Source files
------------

// File: rtl/sft_arb_pkg.sv
// Shared definitions for the shift-engine arbiter: FSM states and engine
// command codes.
package sft_arb_pkg;

  typedef enum logic [1:0] {
    SA_IDLE = 2'd0,
    SA_WAIT = 2'd1,
    SA_HOLD = 2'd2
  } sa_state_e;

  localparam logic [1:0] SFT_CMD_MR    = 2'b00;
  localparam logic [1:0] SFT_CMD_SHIFT = 2'b01;
  localparam logic [1:0] SFT_CMD_STORE = 2'b10;
  localparam logic [1:0] SFT_CMD_OE    = 2'b11;

endpackage

// File: rtl/sft_arb_rr_pick.sv
// Combinational round-robin picker: first set bit of vld searching
// last+1, last+2, ... modulo NREQ. Returns one-hot and index.
module rr_pick #(
  parameter int unsigned NREQ  = 3,
  parameter int unsigned IDX_W = 2
) (
  input  logic [NREQ-1:0]  vld,
  input  logic [IDX_W-1:0] last,
  output logic [NREQ-1:0]  gnt_oh,
  output logic [IDX_W-1:0] gnt_idx
);

  logic [IDX_W-1:0] cand;
  logic             found;

  // Scan the requesters in rotating order and keep the first hit.
  always_comb begin
    gnt_oh  = '0;
    gnt_idx = '0;
    cand    = '0;
    found   = 1'b0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      cand = IDX_W'((32'(last) + k) % NREQ);
      if (!found && vld[cand]) begin
        found         = 1'b1;
        gnt_oh[cand]  = 1'b1;
        gnt_idx       = cand;
      end
    end
  end

endmodule

// File: rtl/sft_arb.sv
// Round-robin arbiter/sequencer sharing one shift-register engine among
// NREQ requesters, with locked multi-command sequences.
// Optional done-timeout abort: define SFT_ARB_TMO_EN.
module sft_arb
  import sft_arb_pkg::*;
#(
  parameter int unsigned NREQ    = 3,
  parameter int unsigned TMO_W   = 16,
  parameter int unsigned TMO_CYC = 16'hFFFF
) (
  input  logic                CLK_I,
  input  logic                RST_I,
  input  logic [NREQ-1:0]     REQ_VLD,
  input  logic [NREQ-1:0]     REQ_LOCK,
  input  logic [2*NREQ-1:0]   REQ_CMD,
  input  logic [NREQ-1:0]     REQ_OEN,
  input  logic [8*NREQ-1:0]   REQ_DIN,
  output logic [NREQ-1:0]     REQ_TAKE,
  output logic [NREQ-1:0]     REQ_ACK,
  output logic [NREQ-1:0]     REQ_GNT,
  output logic                SFT_VLD,
  output logic [1:0]          SFT_CMD,
  output logic                SFT_OEN,
  output logic [7:0]          SFT_DIN,
  input  logic                SFT_DONE,
  output logic                BUSY,
  output logic                ERR
);

  localparam int unsigned IDX_W = $clog2(NREQ);

  if (NREQ < 2 || NREQ > 8) begin : g_bad_nreq
    $error("sft_arb: NREQ must be in 2..8");
  end
  if (TMO_W < 1 || TMO_W > 32 || (TMO_W < 32 && 64'(TMO_CYC) >= (64'd1 << TMO_W))) begin : g_bad_tmo
    $error("sft_arb: TMO_CYC does not fit in TMO_W bits");
  end

  sa_state_e        state_q, state_d;
  logic [NREQ-1:0]  gnt_q, gnt_d;
  logic [IDX_W-1:0] last_q, last_d;
  logic [NREQ-1:0]  take_q, take_d;
  logic [NREQ-1:0]  ack_q, ack_d;
  logic             sft_vld_q, sft_vld_d;
  logic [1:0]       sft_cmd_q, sft_cmd_d;
  logic             sft_oen_q, sft_oen_d;
  logic [7:0]       sft_din_q, sft_din_d;

`ifdef SFT_ARB_TMO_EN
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             err_q, err_d;
`endif

  logic [1:0]       cmd_a [NREQ];
  logic [7:0]       din_a [NREQ];
  logic [NREQ-1:0]  pick_oh;
  logic [IDX_W-1:0] pick_idx;
  logic             load;
  logic [IDX_W-1:0] load_idx;
  logic [NREQ-1:0]  load_oh;
  logic             done_ok;

  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign cmd_a[i] = REQ_CMD[2*i +: 2];
    assign din_a[i] = REQ_DIN[8*i +: 8];
  end

  rr_pick #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .vld     (REQ_VLD),
    .last    (last_q),
    .gnt_oh  (pick_oh),
    .gnt_idx (pick_idx)
  );

  // A done in the SFT_VLD cycle belongs to no command we issued.
  assign done_ok = SFT_DONE && !sft_vld_q;

  // Next-state and registered-output logic. IDLE and HOLD share one load
  // path; only the source of the winning index differs.
  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    last_d    = last_q;
    take_d    = '0;
    ack_d     = '0;
    sft_vld_d = 1'b0;
    sft_cmd_d = sft_cmd_q;
    sft_oen_d = sft_oen_q;
    sft_din_d = sft_din_q;
    load      = 1'b0;
    load_idx  = last_q;
    load_oh   = gnt_q;
`ifdef SFT_ARB_TMO_EN
    tmo_d     = tmo_q;
    err_d     = 1'b0;
`endif

    unique case (state_q)
      SA_IDLE: begin
        if (|REQ_VLD) begin
          load     = 1'b1;
          load_idx = pick_idx;
          load_oh  = pick_oh;
        end
      end
      SA_WAIT: begin
        if (done_ok) begin
          ack_d = gnt_q;
          if (REQ_LOCK[last_q]) begin
            state_d = SA_HOLD;
          end else begin
            state_d = SA_IDLE;
            gnt_d   = '0;
          end
        end
`ifdef SFT_ARB_TMO_EN
        else if (tmo_q == TMO_W'(TMO_CYC)) begin
          ack_d   = gnt_q;
          err_d   = 1'b1;
          state_d = SA_IDLE;
          gnt_d   = '0;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
`endif
      end
      SA_HOLD: begin
        if (REQ_VLD[last_q]) begin
          load = 1'b1;
        end else if (!REQ_LOCK[last_q]) begin
          state_d = SA_IDLE;
          gnt_d   = '0;
        end
      end
      default: begin
        state_d = SA_IDLE;
        gnt_d   = '0;
      end
    endcase

    if (load) begin
      state_d   = SA_WAIT;
      gnt_d     = load_oh;
      last_d    = load_idx;
      take_d    = load_oh;
      sft_vld_d = 1'b1;
      sft_cmd_d = cmd_a[load_idx];
      sft_oen_d = REQ_OEN[load_idx];
      sft_din_d = din_a[load_idx];
`ifdef SFT_ARB_TMO_EN
      tmo_d     = '0;
`endif
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      state_q   <= SA_IDLE;
      gnt_q     <= '0;
      last_q    <= IDX_W'(NREQ - 1);
      take_q    <= '0;
      ack_q     <= '0;
      sft_vld_q <= 1'b0;
      sft_cmd_q <= '0;
      sft_oen_q <= 1'b0;
      sft_din_q <= '0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      last_q    <= last_d;
      take_q    <= take_d;
      ack_q     <= ack_d;
      sft_vld_q <= sft_vld_d;
      sft_cmd_q <= sft_cmd_d;
      sft_oen_q <= sft_oen_d;
      sft_din_q <= sft_din_d;
    end
  end

`ifdef SFT_ARB_TMO_EN
  // Timeout counter and error pulse registers.
  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      tmo_q <= '0;
      err_q <= 1'b0;
    end else begin
      tmo_q <= tmo_d;
      err_q <= err_d;
    end
  end
  assign ERR = err_q;
`else
  assign ERR = 1'b0;
`endif

  assign REQ_TAKE = take_q;
  assign REQ_ACK  = ack_q;
  assign REQ_GNT  = gnt_q;
  assign SFT_VLD  = sft_vld_q;
  assign SFT_CMD  = sft_cmd_q;
  assign SFT_OEN  = sft_oen_q;
  assign SFT_DIN  = sft_din_q;
  assign BUSY     = (state_q != SA_IDLE);

endmodule

// File: tb/tb_sft_arb.sv
// Self-checking bench for sft_arb: directed scenarios plus a randomized run
// against a transaction-level reference model.
module tb_sft_arb;
  import sft_arb_pkg::*;

  localparam int unsigned NREQ = 3;
  localparam int unsigned TMO  = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req_vld, req_lock, req_oen;
  logic [2*NREQ-1:0] req_cmd;
  logic [8*NREQ-1:0] req_din;
  logic [NREQ-1:0]   req_take, req_ack, req_gnt;
  logic              sft_vld, sft_oen, sft_done, busy, err;
  logic [1:0]        sft_cmd;
  logic [7:0]        sft_din;

  int n_checks = 0;
  int n_fail   = 0;

  sft_arb #(
    .NREQ    (NREQ),
    .TMO_W   (16),
    .TMO_CYC (TMO)
  ) dut (
    .CLK_I    (clk),
    .RST_I    (rst),
    .REQ_VLD  (req_vld),
    .REQ_LOCK (req_lock),
    .REQ_CMD  (req_cmd),
    .REQ_OEN  (req_oen),
    .REQ_DIN  (req_din),
    .REQ_TAKE (req_take),
    .REQ_ACK  (req_ack),
    .REQ_GNT  (req_gnt),
    .SFT_VLD  (sft_vld),
    .SFT_CMD  (sft_cmd),
    .SFT_OEN  (sft_oen),
    .SFT_DIN  (sft_din),
    .SFT_DONE (sft_done),
    .BUSY     (busy),
    .ERR      (err)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int r, input logic v, input logic lk,
                         input logic [1:0] c, input logic o, input logic [7:0] d);
    req_vld[r]         = v;
    req_lock[r]        = lk;
    req_cmd[2*r +: 2]  = c;
    req_oen[r]         = o;
    req_din[8*r +: 8]  = d;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    req_vld = '0; req_lock = '0; req_cmd = '0; req_oen = '0; req_din = '0;
    sft_done = 1'b0;
    tick; tick;
    rst = 1'b0;
  endtask

  task automatic test_reset;
    do_reset;
    n_checks++;
    if ({req_take, req_ack, req_gnt, sft_vld, sft_cmd, sft_oen, sft_din, busy, err} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got take=%b ack=%b gnt=%b vld=%b cmd=%b oen=%b din=%h busy=%b err=%b, expected all 0",
               req_take, req_ack, req_gnt, sft_vld, sft_cmd, sft_oen, sft_din, busy, err);
    end
  endtask

  task automatic test_single;
    do_reset;
    set_req(0, 1'b1, 1'b0, SFT_CMD_SHIFT, 1'b1, 8'hA5);
    tick;
    n_checks++;
    if ({req_take, sft_vld, sft_cmd, sft_oen, sft_din, req_gnt, busy} !== {3'b001, 1'b1, 2'b01, 1'b1, 8'hA5, 3'b001, 1'b1}) begin
      n_fail++;
      $display("FAIL single_take: got take=%b vld=%b cmd=%b oen=%b din=%h gnt=%b busy=%b, expected 001 1 01 1 a5 001 1",
               req_take, sft_vld, sft_cmd, sft_oen, sft_din, req_gnt, busy);
    end
    req_vld = '0;
    for (int i = 1; i <= 5; i++) begin
      tick;
      n_checks++;
      if ({req_take, req_ack, sft_vld} !== '0) begin
        n_fail++;
        $display("FAIL single_wait: cycle %0d got take=%b ack=%b vld=%b, expected 0", i, req_take, req_ack, sft_vld);
      end
    end
    sft_done = 1'b1;
    tick;
    sft_done = 1'b0;
    n_checks++;
    if ({req_ack, req_gnt, busy} !== {3'b001, 3'b000, 1'b0}) begin
      n_fail++;
      $display("FAIL single_ack: got ack=%b gnt=%b busy=%b, expected 001 000 0", req_ack, req_gnt, busy);
    end
    tick;
    n_checks++;
    if (req_ack !== 3'b000) begin
      n_fail++;
      $display("FAIL single_ack_pulse: got ack=%b, expected 000", req_ack);
    end
  endtask

  task automatic test_contention;
    logic [NREQ-1:0] exp;
    int n;
    do_reset;
    req_vld = 3'b111;
    for (int g = 0; g < 6; g++) begin
      exp = '0;
      exp[g % NREQ] = 1'b1;
      n = 0;
      while (req_take == '0 && n < 10) begin tick; n++; end
      n_checks++;
      if ({req_take, req_gnt, sft_vld} !== {exp, exp, 1'b1}) begin
        n_fail++;
        $display("FAIL contention_grant%0d: got take=%b gnt=%b vld=%b, expected %b %b 1", g, req_take, req_gnt, sft_vld, exp, exp);
      end
      tick; tick; tick;
      sft_done = 1'b1;
      tick;
      sft_done = 1'b0;
      n_checks++;
      if (req_ack !== exp) begin
        n_fail++;
        $display("FAIL contention_ack%0d: got ack=%b, expected %b", g, req_ack, exp);
      end
      tick;
      n_checks++;
      if (req_ack !== 3'b000) begin
        n_fail++;
        $display("FAIL contention_ack_pulse%0d: got ack=%b, expected 000", g, req_ack);
      end
    end
    req_vld = '0;
    tick; tick; tick; tick;
    sft_done = 1'b1; tick; sft_done = 1'b0; tick;
  endtask

  task automatic test_lock;
    int n;
    logic [7:0] d;
    do_reset;
    for (int k = 0; k < 9; k++) begin
      d = (k < 8) ? 8'(1 << k) : 8'h00;
      set_req(1, 1'b1, (k < 8), (k < 8) ? SFT_CMD_SHIFT : SFT_CMD_STORE, 1'b0, d);
      n = 0;
      while (req_take == '0 && n < 10) begin tick; n++; end
      n_checks++;
      if ({req_take, req_gnt, sft_cmd, sft_din} !== {3'b010, 3'b010, ((k < 8) ? 2'b01 : 2'b10), d}) begin
        n_fail++;
        $display("FAIL lock_take%0d: got take=%b gnt=%b cmd=%b din=%h, expected 010 010 %b %h",
                 k, req_take, req_gnt, sft_cmd, sft_din, (k < 8) ? 2'b01 : 2'b10, d);
      end
      req_vld[1] = 1'b0;
      if (k == 0) begin req_vld[0] = 1'b1; req_vld[2] = 1'b1; end
      tick; tick;
      n_checks++;
      if (req_gnt !== 3'b010) begin
        n_fail++;
        $display("FAIL lock_gnt_wait%0d: got gnt=%b, expected 010", k, req_gnt);
      end
      sft_done = 1'b1;
      tick;
      sft_done = 1'b0;
      n_checks++;
      if ({req_ack, req_gnt} !== {3'b010, (k < 8) ? 3'b010 : 3'b000}) begin
        n_fail++;
        $display("FAIL lock_ack%0d: got ack=%b gnt=%b, expected 010 %b", k, req_ack, req_gnt, (k < 8) ? 3'b010 : 3'b000);
      end
    end
    n = 0;
    while (req_take == '0 && n < 10) begin tick; n++; end
    n_checks++;
    if (req_take !== 3'b100) begin
      n_fail++;
      $display("FAIL lock_next_grant: got take=%b, expected 100", req_take);
    end
    req_vld = '0;
    tick; sft_done = 1'b1; tick; sft_done = 1'b0; tick;
  endtask

  task automatic test_spurious_done;
    int acks;
    do_reset;
    sft_done = 1'b1;
    tick;
    sft_done = 1'b0;
    n_checks++;
    if ({req_ack, busy} !== '0) begin
      n_fail++;
      $display("FAIL spurious_idle: got ack=%b busy=%b, expected 000 0", req_ack, busy);
    end
    set_req(0, 1'b1, 1'b0, SFT_CMD_OE, 1'b0, 8'h3C);
    tick;
    req_vld = '0;
    sft_done = 1'b1;
    tick;
    sft_done = 1'b0;
    n_checks++;
    if ({req_ack, req_gnt} !== {3'b000, 3'b001}) begin
      n_fail++;
      $display("FAIL spurious_vld_cycle: got ack=%b gnt=%b, expected 000 001", req_ack, req_gnt);
    end
    tick; tick;
    sft_done = 1'b1;
    tick;
    sft_done = 1'b0;
    acks = (req_ack == 3'b001) ? 1 : 0;
    for (int i = 0; i < 4; i++) begin
      tick;
      if (req_ack != '0) acks++;
    end
    n_checks++;
    if (acks !== 1) begin
      n_fail++;
      $display("FAIL spurious_real_ack: got %0d acks, expected 1", acks);
    end
  endtask

  task automatic test_reset_mid_wait;
    int acks;
    do_reset;
    set_req(0, 1'b1, 1'b1, SFT_CMD_SHIFT, 1'b1, 8'h5A);
    tick;
    req_vld = '0;
    tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    n_checks++;
    if ({req_take, req_ack, req_gnt, sft_vld, sft_cmd, sft_oen, sft_din, busy, err} !== '0) begin
      n_fail++;
      $display("FAIL rst_mid_wait_outputs: got take=%b ack=%b gnt=%b vld=%b cmd=%b oen=%b din=%h busy=%b err=%b, expected all 0",
               req_take, req_ack, req_gnt, sft_vld, sft_cmd, sft_oen, sft_din, busy, err);
    end
    acks = 0;
    sft_done = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick;
      if (req_ack != '0) acks++;
    end
    sft_done = 1'b0;
    n_checks++;
    if (acks !== 0) begin
      n_fail++;
      $display("FAIL rst_mid_wait_noack: got %0d acks, expected 0", acks);
    end
    req_lock = '0;
    set_req(1, 1'b1, 1'b0, SFT_CMD_SHIFT, 1'b0, 8'h11);
    set_req(2, 1'b1, 1'b0, SFT_CMD_SHIFT, 1'b0, 8'h22);
    tick;
    n_checks++;
    if ({req_take, sft_din} !== {3'b010, 8'h11}) begin
      n_fail++;
      $display("FAIL rst_mid_wait_regrant: got take=%b din=%h, expected 010 11", req_take, sft_din);
    end
    req_vld = '0;
    tick; sft_done = 1'b1; tick; sft_done = 1'b0; tick;
  endtask

`ifdef SFT_ARB_TMO_EN
  task automatic test_timeout;
    do_reset;
    for (int pass = 0; pass < 2; pass++) begin
      set_req(0, 1'b1, 1'b1, SFT_CMD_SHIFT, 1'b0, 8'h77);
      tick;
      req_vld = '0;
      for (int i = 1; i <= 16; i++) begin
        tick;
        n_checks++;
        if ({err, req_ack} !== '0) begin
          n_fail++;
          $display("FAIL tmo_early%0d: cycle %0d got err=%b ack=%b, expected 0 000", pass, i, err, req_ack);
        end
      end
      if (pass == 1) sft_done = 1'b1;
      tick;
      sft_done = 1'b0;
      if (pass == 0) begin
        n_checks++;
        if ({err, req_ack, req_gnt, busy} !== {1'b1, 3'b001, 3'b000, 1'b0}) begin
          n_fail++;
          $display("FAIL tmo_expire: got err=%b ack=%b gnt=%b busy=%b, expected 1 001 000 0", err, req_ack, req_gnt, busy);
        end
      end else begin
        n_checks++;
        if ({err, req_ack, req_gnt} !== {1'b0, 3'b001, 3'b001}) begin
          n_fail++;
          $display("FAIL tmo_done_wins: got err=%b ack=%b gnt=%b, expected 0 001 001", err, req_ack, req_gnt);
        end
      end
      req_lock = '0;
      tick; tick;
    end
  endtask
`endif

  // Randomized traffic against a transaction-level model: an owner index,
  // whether a command is outstanding, and whether this is the strobe cycle.
  task automatic test_random;
    int m_owner, m_last, m_wait, issue;
    bit m_cmd, m_fresh;
    logic [NREQ-1:0] e_take, e_ack, e_gnt;
    logic e_err, e_vld, e_oen;
    logic [1:0] e_cmd;
    logic [7:0] e_din;
    do_reset;
    m_owner = -1; m_last = NREQ - 1; m_cmd = 0; m_fresh = 0; m_wait = 0;
    e_cmd = '0; e_oen = 1'b0; e_din = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int r = 0; r < NREQ; r++) begin
        if (!req_vld[r] && $urandom_range(2) == 0)
          set_req(r, 1'b1, req_lock[r], 2'($urandom), 1'($urandom), 8'($urandom));
        req_lock[r] = ($urandom_range(3) != 0);
      end
      sft_done = ($urandom_range(9) < 3);

      e_take = '0; e_ack = '0; e_err = 1'b0; issue = -1;
      if (m_owner < 0) begin
        for (int k = 1; k <= NREQ; k++)
          if (issue < 0 && req_vld[(m_last + k) % NREQ]) issue = (m_last + k) % NREQ;
      end else if (!m_cmd) begin
        if (req_vld[m_owner]) issue = m_owner;
        else if (!req_lock[m_owner]) m_owner = -1;
      end else if (m_fresh) begin
        m_fresh = 0;
        m_wait++;
      end else if (sft_done) begin
        e_ack[m_owner] = 1'b1;
        m_cmd = 0;
        if (!req_lock[m_owner]) m_owner = -1;
      end
`ifdef SFT_ARB_TMO_EN
      else if (m_wait == TMO) begin
        e_ack[m_owner] = 1'b1;
        e_err = 1'b1;
        m_cmd = 0;
        m_owner = -1;
      end
`endif
      else begin
        m_wait++;
      end
      if (issue >= 0) begin
        m_owner = issue; m_last = issue; m_cmd = 1; m_fresh = 1; m_wait = 0;
        e_take[issue] = 1'b1;
        e_cmd = req_cmd[2*issue +: 2];
        e_oen = req_oen[issue];
        e_din = req_din[8*issue +: 8];
      end
      e_vld = (issue >= 0);
      e_gnt = '0;
      if (m_owner >= 0) e_gnt[m_owner] = 1'b1;

      tick;
      n_checks++;
      if ({req_take, req_ack, req_gnt, sft_vld, busy, err, sft_cmd, sft_oen, sft_din} !==
          {e_take, e_ack, e_gnt, e_vld, (m_owner >= 0), e_err, e_cmd, e_oen, e_din}) begin
        n_fail++;
        $display("FAIL random_cycle%0d: got take=%b ack=%b gnt=%b vld=%b busy=%b err=%b cmd=%b oen=%b din=%h, expected %b %b %b %b %b %b %b %b %h",
                 cyc, req_take, req_ack, req_gnt, sft_vld, busy, err, sft_cmd, sft_oen, sft_din,
                 e_take, e_ack, e_gnt, e_vld, (m_owner >= 0), e_err, e_cmd, e_oen, e_din);
      end
      for (int r = 0; r < NREQ; r++)
        if (e_take[r]) req_vld[r] = 1'b0;
    end
    sft_done = 1'b0;
    req_vld = '0;
  endtask

  initial begin
    rst = 1'b1;
    req_vld = '0; req_lock = '0; req_cmd = '0; req_oen = '0; req_din = '0;
    sft_done = 1'b0;
    test_reset;
    test_single;
    test_contention;
    test_lock;
    test_spurious_done;
    test_reset_mid_wait;
`ifdef SFT_ARB_TMO_EN
    test_timeout;
`endif
    test_random;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
